wb_slave_regfile: RTL and testbench

- Wishbone B4 pipelined slave exposing a bank of REGISTER_NUM read/write registers, DATA_WIDTH bits each.
- Byte-lane writes are controlled by sel_i.
- Sits behind a Wishbone master/interconnect as a memory-mapped register block.
- Responds with a registered ack_o or err_o one cycle after a request is accepted.

---
 rtl/wb_slave_pkg.sv | 21 ++
 rtl/wb_regfile.sv | 42 ++++
 rtl/wb_slave_regfile.sv | 91 +++++++++
 tb/tb_wb_slave_regfile.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_pkg.sv
// wb_slave_pkg: default sizing and bus word types for the Wishbone register-file slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_slave_pkg;

  localparam int ADDR_WIDTH   = 16;
  localparam int DATA_WIDTH   = 32;
  localparam int GRANULE      = 8;
  localparam int REGISTER_NUM = 16;
  localparam int SEL_WIDTH    = DATA_WIDTH / GRANULE;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [SEL_WIDTH-1:0]  sel_t;

  // Width of a register index; kept at least 1 so a single-register bank still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// wb_regfile: REGISTER_NUM x DATA_WIDTH storage, one byte-lane write port, one combinational read port.
// Latency: write commits at the clock edge; read data is combinational from raddr.
// Backpressure: none; a write is taken every cycle we is high.
// Ports: clk/rst (sync, active-low), we/waddr/wsel/wdat write port, raddr/rdat read port.
module wb_regfile
  import wb_slave_pkg::*;
#(
  parameter int DATA_WIDTH   = wb_slave_pkg::DATA_WIDTH,
  parameter int GRANULE      = wb_slave_pkg::GRANULE,
  parameter int REGISTER_NUM = wb_slave_pkg::REGISTER_NUM,
  parameter int SEL_WIDTH    = DATA_WIDTH / GRANULE,
  parameter int IDX_WIDTH    = idx_width(REGISTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [SEL_WIDTH-1:0]  wsel,
  input  logic [DATA_WIDTH-1:0] wdat,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdat
);

  logic [DATA_WIDTH-1:0] mem [REGISTER_NUM];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REGISTER_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (wsel[k]) begin
          mem[waddr][k*GRANULE +: GRANULE] <= wdat[k*GRANULE +: GRANULE];
        end
      end
    end
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone B4 pipelined slave in front of a byte-lane register bank.
// Latency: ack_o/err_o (and read data) one cycle after the accepting edge; one request per cycle.
// Backpressure: stall_o only during and directly after reset; responses are dropped if cyc_i falls.
// Ports: clk_i, rst_i (sync active-low), adr_i/dat_i/sel_i/we_i/stb_i/cyc_i request,
//        dat_o/ack_o/err_o response, stall_o pipeline stall.
module wb_slave_regfile
  import wb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH   = wb_slave_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = wb_slave_pkg::DATA_WIDTH,
  parameter int GRANULE      = wb_slave_pkg::GRANULE,
  parameter int REGISTER_NUM = wb_slave_pkg::REGISTER_NUM,
  localparam int SEL_WIDTH   = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int IDX_WIDTH = idx_width(REGISTER_NUM);
  // One extra bit so REGISTER_NUM == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REGISTER_NUM);

  logic                  stall_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  accept;
  logic                  valid;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rdat;

  assign accept = cyc_i & stb_i & ~stall_q;
  // Full address is compared, so upper bits never alias onto the bank.
  assign valid  = ({1'b0, adr_i} < REG_LIMIT) && (sel_i != '0);

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      lane_mask[k*GRANULE +: GRANULE] = {GRANULE{sel_i[k]}};
    end
  end

  wb_regfile #(
    .DATA_WIDTH   (DATA_WIDTH),
    .GRANULE      (GRANULE),
    .REGISTER_NUM (REGISTER_NUM),
    .SEL_WIDTH    (SEL_WIDTH),
    .IDX_WIDTH    (IDX_WIDTH)
  ) u_regfile (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (accept & valid & we_i),
    .waddr (adr_i[IDX_WIDTH-1:0]),
    .wsel  (sel_i),
    .wdat  (dat_i),
    .raddr (adr_i[IDX_WIDTH-1:0]),
    .rdat  (rdat)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      stall_q <= 1'b0;
      ack_q   <= accept & valid;
      err_q   <= accept & ~valid;
      // Read data is sampled before the same edge's write could land; only reads return data.
      dat_q   <= (accept & valid & ~we_i) ? (rdat & lane_mask) : '0;
    end
  end

  // A master that drops cyc_i abandons the cycle: the pending response never reaches the bus.
  assign ack_o   = ack_q & cyc_i;
  assign err_o   = err_q & cyc_i;
  assign dat_o   = cyc_i ? dat_q : '0;
  assign stall_o = stall_q;

endmodule

// File: tb/tb_wb_slave_regfile.sv
module tb_wb_slave_regfile;
  import wb_slave_pkg::*;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst;
  addr_t adr;
  data_t wdat;
  data_t rdat;
  sel_t  sel;
  logic  we, stb, cyc;
  logic  ack, err, stall;

  wb_slave_regfile dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .adr_i   (adr),
    .dat_i   (wdat),
    .dat_o   (rdat),
    .sel_i   (sel),
    .we_i    (we),
    .stb_i   (stb),
    .cyc_i   (cyc),
    .ack_o   (ack),
    .err_o   (err),
    .stall_o (stall)
  );

  typedef struct {
    logic  is_err;
    data_t dat;
    int    edge_n;
  } exp_t;

  exp_t  q[$];
  data_t model [REGISTER_NUM];
  int    checks   = 0;
  int    failures = 0;
  int    edge_cnt = 0;
  bit    mon_en   = 0;
  bit    pend_v   = 0;
  exp_t  pend;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic data_t lanes(input sel_t s);
    data_t m = '0;
    for (int k = 0; k < SEL_WIDTH; k++)
      if (s[k]) m[k*GRANULE +: GRANULE] = {GRANULE{1'b1}};
    return m;
  endfunction

  // One bus cycle. A response from the previous cycle only counts if cyc is still high now.
  task automatic step(input bit c, input bit s, input bit w, input addr_t a,
                      input sel_t se, input data_t d);
    data_t m;
    if (pend_v) begin
      if (c) q.push_back(pend);
      pend_v = 0;
    end
    cyc = c; stb = s; we = w; adr = a; sel = se; wdat = d;
    if (c && s) begin
      chk("stall_idle", stall, 0);
      pend.edge_n = edge_cnt + 1;
      pend.dat    = '0;
      pend.is_err = !((a < REGISTER_NUM) && (se != 0));
      if (!pend.is_err) begin
        m = lanes(se);
        if (w) model[a] = (model[a] & ~m) | (d & m);
        else   pend.dat = model[a] & m;
      end
      pend_v = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < REGISTER_NUM; i++) model[i] = '0;
    q.delete();
    pend_v = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("ack_err_together", ack && err, 0);
      if (ack || err) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual=ack%0b/err%0b required=none (t=%0t)", ack, err, $time);
        end else begin
          e = q.pop_front();
          chk("resp_is_err", err, e.is_err);
          chk("resp_dat", rdat, e.dat);
          chk("resp_latency_edge", edge_cnt, e.edge_n);
        end
      end else begin
        chk("idle_dat", rdat, 0);
        if (q.size() > 0 && q[0].edge_n <= edge_cnt) begin
          checks++; failures++;
          $display("FAIL missing_resp actual=none required=resp_at_edge%0d (t=%0t)", q[0].edge_n, $time);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; wdat = '0;
    mon_en = 0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", stall, 0);
    mon_en = 1;
  endtask

  initial begin
    bit    c, s, w;
    addr_t a;
    sel_t  se;
    int    r;

    do_reset();

    // Reset contents, full-width write/read.
    step(1, 1, 0, 16'd3, 4'hF, '0);
    step(1, 1, 1, 16'd5, 4'hF, 32'hDEADBEEF);
    step(1, 1, 0, 16'd5, 4'hF, '0);

    // Byte lanes: expect 0x11BB33DD full, 0x000033DD with sel 0011.
    step(1, 1, 1, 16'd2, 4'hF, 32'h11223344);
    step(1, 1, 1, 16'd2, 4'b0101, 32'hAABBCCDD);
    step(1, 1, 0, 16'd2, 4'hF, '0);
    step(1, 1, 0, 16'd2, 4'b0011, '0);

    // Error terminations, then reg 0 still untouched.
    step(1, 1, 1, 16'd16, 4'hF, 32'h12345678);
    step(1, 1, 1, 16'hFFFF, 4'hF, 32'h87654321);
    step(1, 1, 1, 16'd0, 4'h0, 32'hFFFFFFFF);
    step(1, 1, 0, 16'd0, 4'h0, '0);
    step(1, 1, 0, 16'd0, 4'hF, '0);

    // Back-to-back writes then immediate read-after-write.
    for (int i = 0; i < 4; i++) step(1, 1, 1, addr_t'(i), 4'hF, 32'hA0A0_0000 + i);
    step(1, 1, 0, 16'd3, 4'hF, '0);

    // Abort: cyc drops the cycle after a write; the write still lands.
    step(1, 1, 1, 16'd7, 4'hF, 32'hCAFEF00D);
    step(0, 0, 0, '0, '0, '0);
    step(1, 1, 0, 16'd7, 4'hF, '0);

    // stb without cyc is ignored.
    step(0, 1, 1, 16'd8, 4'hF, 32'h00001234);
    step(1, 1, 0, 16'd8, 4'hF, '0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      c = ($urandom % 8) != 0;
      s = ($urandom % 4) != 0;
      w = $urandom % 2;
      r = $urandom % 10;
      if (r == 0)      a = addr_t'(REGISTER_NUM + ($urandom % 8));
      else if (r == 1) a = addr_t'($urandom);
      else             a = addr_t'($urandom % REGISTER_NUM);
      se = (($urandom % 8) == 0) ? sel_t'(0) : sel_t'($urandom);
      step(c, s, w, a, se, data_t'($urandom));
    end
    repeat (3) step(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    chk("queue_drained", q.size(), 0);

    // Reset while a response is pending: it must not appear, and contents clear.
    step(1, 1, 1, 16'd4, 4'hF, 32'h55AA55AA);
    do_reset();
    step(1, 1, 0, 16'd4, 4'hF, '0);
    step(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    chk("queue_drained_end", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
